// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests to imem and buffers in-order responses for the decoder.
// A response reaches the decoder 1 cycle after arrival; requests stall while no buffer credit is free.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t        buf_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [OW-1:0] outstanding_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   last_pc;
  logic [31:0]   redirect_pc_al;
  logic [SW-1:0] credits_used;
  entry_t        head;
  logic          req_fire;
  logic          resp_take;
  logic          resp_drop;
  logic          resp_keep;
  logic          pop;

  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

  // Buffered plus kept-in-flight instructions: a request is only issued when its response is
  // guaranteed a FIFO slot, so responses never need backpressure.
  assign credits_used   = SW'(count) + SW'(outstanding - drop_cnt);
  assign imem_req_valid = !rst && !redirect
                          && (outstanding < OW'(MAX_OUTSTANDING))
                          && (credits_used < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign resp_take = imem_resp_valid && (outstanding != '0);
  assign resp_drop = resp_take && (redirect || (drop_cnt != '0));
  assign resp_keep = resp_take && !resp_drop;

  assign head       = buf_q[rd_ptr];
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.inst : NOP;
  assign inst_pc    = inst_valid ? head.pc : last_pc;
  assign pop        = inst_valid && inst_ready;

  assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(resp_take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      last_pc     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (inst_valid) last_pc <= head.pc;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc <= redirect_pc_al;
        resp_pc  <= redirect_pc_al;
        drop_cnt <= outstanding_nxt;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp_keep) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (resp_drop) drop_cnt <= drop_cnt - OW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(resp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resp_keep) buf_q[wr_ptr] <= {imem_resp_data, resp_pc};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a stream-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the fetch stream is a run of consecutive word addresses per epoch
  // (epoch bumps on redirect/reset); memory answers in order and keeps epoch tags.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          cyc;
  } req_t;

  req_t        q[$];
  logic [31:0] fires[$];
  logic [31:0] pops[$];
  logic [31:0] fetch_m;
  logic [31:0] exp_pc;
  int buffered, epoch, cyc_n, checks, errors;
  int first_fire, first_valid, dut_pops;
  int mem_rdy_pct, inst_rdy_pct, resp_pct;
  logic found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] qq[$], input int idx);
    return (qq.size() > idx) ? qq[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_pcts(input int m, input int i, input int r);
    mem_rdy_pct  = m;
    inst_rdy_pct = i;
    resp_pct     = r;
  endtask

  // Called at a falling edge: drive one cycle of inputs, check outputs, update model.
  task automatic cycle(input logic rdir, input logic [31:0] rpc);
    logic mrdy, irdy, do_resp, exp_valid, kept, pop;
    int   live;
    req_t r;
    mrdy    = int'($urandom_range(99)) < mem_rdy_pct;
    irdy    = int'($urandom_range(99)) < inst_rdy_pct;
    do_resp = 1'b0;
    if (q.size() != 0 && int'($urandom_range(99)) < resp_pct) do_resp = (q[0].cyc < cyc_n);
    redirect        = rdir;
    redirect_pc     = rpc;
    imem_req_ready  = mrdy;
    inst_ready      = irdy;
    imem_resp_valid = do_resp;
    if (do_resp) imem_resp_data = mem_word(q[0].addr);
    else         imem_resp_data = $urandom();
    #1;
    live      = int'((fetch_m - exp_pc) >> 2);
    exp_valid = !rdir && (q.size() < MAX_OUT) && (live < DEPTH);
    chk1("req_valid", imem_req_valid, exp_valid);
    chk32("req_addr", imem_req_addr, fetch_m);
    chk1("inst_valid", inst_valid, buffered != 0);
    if (first_fire < 0 && exp_valid && mrdy) first_fire = cyc_n;
    if (first_valid < 0 && inst_valid) first_valid = cyc_n;
    if (inst_valid && irdy) dut_pops++;
    pop = (buffered != 0) && irdy;
    if (pop) begin
      chk32("inst_pc", inst_pc, exp_pc);
      chk32("inst", inst, mem_word(exp_pc));
      pops.push_back(inst_pc);
      exp_pc += 32'd4;
    end
    kept = 1'b0;
    if (do_resp) begin
      r    = q.pop_front();
      kept = (r.epoch == epoch) && !rdir;
    end
    if (exp_valid && mrdy) begin
      q.push_back('{addr: fetch_m, epoch: epoch, cyc: cyc_n});
      fires.push_back(imem_req_addr);
      fetch_m += 32'd4;
    end
    buffered = buffered + int'(kept) - int'(pop);
    if (rdir) begin
      epoch++;
      buffered = 0;
      fetch_m  = rpc & 32'hFFFF_FFFC;
      exp_pc   = fetch_m;
      fires.delete();
      pops.delete();
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk32("rst_req_addr", imem_req_addr, RESET_PC);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk32("rst_inst", inst, 32'h0000_0013);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    q.delete();
    fires.delete();
    pops.delete();
    buffered    = 0;
    epoch++;
    fetch_m     = RESET_PC;
    exp_pc      = RESET_PC;
    first_fire  = -1;
    first_valid = -1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
    checks = 0; errors = 0; epoch = 0; cyc_n = 0; dut_pops = 0; buffered = 0;
    first_fire = -1; first_valid = -1; fetch_m = RESET_PC; exp_pc = RESET_PC;
    set_pcts(100, 100, 100);
    @(negedge clk);
    do_reset();

    // Streaming from reset with 1-cycle memory.
    for (int i = 0; i < 8; i++) cycle(1'b0, $urandom());
    chk32("first_latency", 32'(first_valid - first_fire), 32'd2);
    chk32("fire0", q_at(fires, 0), RESET_PC);
    chk32("fire1", q_at(fires, 1), RESET_PC + 32'd4);
    chk32("fire2", q_at(fires, 2), RESET_PC + 32'd8);
    chk32("pop1", q_at(pops, 1), RESET_PC + 32'd4);

    // Decoder stall fills the buffer and blocks requests.
    set_pcts(100, 0, 100);
    for (int i = 0; i < 10; i++) cycle(1'b0, $urandom());
    chk1("stall_inst_valid", inst_valid, 1'b1);
    chk1("stall_req_blocked", imem_req_valid, 1'b0);
    set_pcts(100, 100, 100);
    for (int i = 0; i < 6; i++) cycle(1'b0, $urandom());

    // Two requests in flight, then redirect before their responses.
    set_pcts(0, 100, 100);
    for (int i = 0; i < 4; i++) cycle(1'b0, $urandom());
    set_pcts(100, 100, 0);
    cycle(1'b1, 32'h10);
    for (int i = 0; i < 3; i++) cycle(1'b0, $urandom());
    chk1("t3_blocked", imem_req_valid, 1'b0);
    chk32("t3_next_addr", imem_req_addr, 32'h18);
    cycle(1'b1, 32'h200);
    chk1("t3_flushed", inst_valid, 1'b0);
    chk32("t3_nop", inst, 32'h0000_0013);
    chk32("t3_addr", imem_req_addr, 32'h200);
    set_pcts(100, 100, 100);
    for (int i = 0; i < 8; i++) cycle(1'b0, $urandom());
    chk32("t3_first_fire", q_at(fires, 0), 32'h200);
    chk32("t3_first_pc", q_at(pops, 0), 32'h200);

    // Back-to-back redirects: last one wins.
    cycle(1'b1, 32'h1000);
    cycle(1'b1, 32'h2000);
    for (int i = 0; i < 8; i++) cycle(1'b0, $urandom());
    chk32("b2b_first_pc", q_at(pops, 0), 32'h2000);

    // Redirect coinciding with a pop and a response, misaligned target.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (buffered != 0 && q.size() != 0 && q[0].cyc < cyc_n) found = 1'b1;
      else cycle(1'b0, $urandom());
    end
    chk1("t4_setup", found, 1'b1);
    cycle(1'b1, 32'h203);
    chk1("t4_flushed", inst_valid, 1'b0);
    chk32("t4_addr", imem_req_addr, 32'h200);
    for (int i = 0; i < 8; i++) cycle(1'b0, $urandom());
    chk32("t4_first_pc", q_at(pops, 0), 32'h200);

    // Address wrap at the top of the address space.
    cycle(1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 12; i++) cycle(1'b0, $urandom());
    chk32("wrap_fire2", q_at(fires, 2), 32'h0);
    chk32("wrap_pop1", q_at(pops, 1), 32'hFFFF_FFFC);
    chk32("wrap_pop2", q_at(pops, 2), 32'h0);

    // Reset with instructions buffered and requests in flight.
    set_pcts(60, 40, 60);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (buffered != 0 && q.size() != 0) found = 1'b1;
      else cycle(1'b0, $urandom());
    end
    chk1("t6_setup", found, 1'b1);
    do_reset();
    set_pcts(100, 100, 100);
    for (int i = 0; i < 6; i++) cycle(1'b0, $urandom());
    chk32("t6_restart_fire", q_at(fires, 0), RESET_PC);
    chk32("t6_restart_pc", q_at(pops, 0), RESET_PC);

    // Random traffic.
    dut_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0)
        set_pcts(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
                 int'($urandom_range(100, 20)));
      if (int'($urandom_range(99)) < 4) begin
        if ($urandom_range(3) == 0) cycle(1'b1, 32'hFFFF_FFF0 | 32'($urandom_range(15)));
        else                        cycle(1'b1, $urandom());
      end else begin
        cycle(1'b0, $urandom());
      end
      if (fires.size() > 64) fires.delete();
      if (pops.size() > 64) pops.delete();
    end
    chk1("rand_progress", dut_pops > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {inst, inst_pc} to the decoder with a valid/ready handshake.
- Accepts a redirect (taken branch or jump, from the pc_src logic) that flushes buffered and in-flight instructions.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max imem requests in flight (<=FIFO_DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_resp_valid  in  1  response valid, in request order, no backpressure
imem_resp_data  in  32  fetched instruction
redirect  in  1  one-cycle pulse: change fetch stream
redirect_pc  in  32  new PC; bits [1:0] ignored (forced 00)
inst_valid  out  1  inst/inst_pc valid to decoder
inst_ready  in  1  decoder consumes current instruction
inst  out  32  instruction to decoder (FIFO head)
inst_pc  out  32  PC of inst

Behaviour:
- Reset (async assert, sync-style release):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO count=0, outstanding=0, drop_cnt=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0.
- Requests:
  - imem_req_addr=fetch_pc always.
  - imem_req_valid=1 iff !redirect && outstanding<MAX_OUTSTANDING && count+(outstanding-drop_cnt)<FIFO_DEPTH.
  - This credit rule guarantees every kept response has a FIFO slot.
  - Request fire (valid&&ready): fetch_pc+=4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding+=1.
- Responses:
  - Each imem_resp_valid decrements outstanding.
  - If drop_cnt>0 (or redirect this cycle): discard the response, drop_cnt-=1 (when >0).
  - Otherwise push {imem_resp_data, resp_pc} into the FIFO and set resp_pc+=4.
  - Response-to-inst_valid latency: 1 cycle (registered FIFO write, head visible next cycle).
- Decoder side:
  - inst_valid=(count!=0); inst/inst_pc=head entry.
  - Pop on inst_valid&&inst_ready.
  - When empty: inst=NOP, inst_pc holds the last value.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (cycle R):
  - Pop handshake in R completes normally, then the FIFO is flushed (count=0).
  - drop_cnt = outstanding after this cycle's request and response, minus kept-response adjustments; all in-flight requests issued before R+1 are discarded.
  - A response arriving in R is dropped.
  - fetch_pc=resp_pc={redirect_pc[31:2],2'b00} at R+1.
  - imem_req_valid=0 in R; first new request possible in R+1.
  - Back-to-back redirects: the last one wins, drop accounting stays cumulative.
- Counters:
  - outstanding and drop_cnt are clog2(MAX_OUTSTANDING)+1 bits; count is clog2(FIFO_DEPTH)+1 bits.
  - Each never over- or underflows given an in-order memory.
  - A response with outstanding==0 is a protocol error: ignored, counters saturate at 0.
- Reset mid-operation clears all state. The instruction memory must share rst, so no stale responses arrive after release.

Test Plan:
- Reset release, imem ready always, 1-cycle response, inst_ready=1 -> req addrs 0x0,0x4,0x8...; inst_valid first high 2 cycles after first req fire; inst_pc 0x0,0x4 in order.
- inst_ready=0 for 10 cycles -> count reaches 2, imem_req_valid drops after 2 credits are used, no response is lost; on release, instructions pop in order with correct PCs.
- Two requests in flight (0x10, 0x14), redirect to 0x200 before responses -> both responses discarded, FIFO empty, next req addr 0x200, first inst_pc=0x200.
- Redirect with redirect_pc=0x203 in the same cycle as a response and a pop -> popped instruction counts, response dropped, fetch resumes at 0x200.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000; inst_pc sequence wraps identically.
- Assert rst with outstanding=2 and count=1 -> all outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
